watch_top: RTL and testbench



---
 rtl/watch_pkg.sv | 6 +
 rtl/watch_counter.sv | 31 +++
 rtl/watch_top.sv | 58 +++++
 tb/tb_watch_top.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared limits for the watch timekeeping counters.
package watch_pkg;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
endpackage

// File: rtl/watch_counter.sv
// Modulo (MAX+1) counter stage with a combinational carry-out for cascading.
module watch_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_carry
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_max;

    assign at_max = (cnt_q == MAX_V);

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc) cnt_d = at_max ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_cnt   = cnt_q;
    assign o_carry = i_inc & at_max;
endmodule

// File: rtl/watch_top.sv
// Free-running watch: programmable prescaler produces a 1 s tick that drives
// cascaded sec/min/hour/day counters; carries ripple within a single edge.
module watch_top
    import watch_pkg::*;
#(
    parameter int P_COUNT_BIT = 30,
    parameter int P_SEC_BIT   = 6,
    parameter int P_MIN_BIT   = 6,
    parameter int P_HOUR_BIT  = 5,
    parameter int P_DAY_BIT   = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_run_en,
    input  logic [P_COUNT_BIT-1:0] i_freq,
    output logic [P_SEC_BIT-1:0]   o_sec,
    output logic [P_MIN_BIT-1:0]   o_min,
    output logic [P_HOUR_BIT-1:0]  o_hour,
    output logic [P_DAY_BIT-1:0]   o_day
);
    logic [P_COUNT_BIT-1:0] pre_q, pre_d;
    logic                   last_cycle, tick;
    logic                   sec_carry, min_carry, hour_carry, day_carry_unused;

    // >= rather than == so a lowered i_freq fires at once instead of wrapping the prescaler
    assign last_cycle = (i_freq <= P_COUNT_BIT'(1)) || (pre_q >= i_freq - P_COUNT_BIT'(1));
    assign tick       = i_run_en & last_cycle;

    always_comb begin
        pre_d = pre_q;
        if (i_run_en) pre_d = last_cycle ? '0 : pre_q + P_COUNT_BIT'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
    end

    watch_counter #(.W(P_SEC_BIT), .MAX(SEC_MAX)) u_sec (
        .clk(clk), .reset(reset), .i_inc(tick),
        .o_cnt(o_sec), .o_carry(sec_carry)
    );

    watch_counter #(.W(P_MIN_BIT), .MAX(MIN_MAX)) u_min (
        .clk(clk), .reset(reset), .i_inc(sec_carry),
        .o_cnt(o_min), .o_carry(min_carry)
    );

    watch_counter #(.W(P_HOUR_BIT), .MAX(HOUR_MAX)) u_hour (
        .clk(clk), .reset(reset), .i_inc(min_carry),
        .o_cnt(o_hour), .o_carry(hour_carry)
    );

    watch_counter #(.W(P_DAY_BIT), .MAX((1 << P_DAY_BIT) - 1)) u_day (
        .clk(clk), .reset(reset), .i_inc(hour_carry),
        .o_cnt(o_day), .o_carry(day_carry_unused)
    );
endmodule

// File: tb/tb_watch_top.sv
// Bench for watch_top: elapsed-seconds model checked every cycle, plus literal
// checkpoints and standalone wrap checks of the counter stage.
module tb_watch_top;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run_en = 1'b0;
    logic [29:0] freq = 30'd10;
    logic [5:0]  o_sec;
    logic [5:0]  o_min;
    logic [4:0]  o_hour;
    logic [8:0]  o_day;

    logic        dc_inc = 1'b0;
    logic [8:0]  dc_cnt;
    logic        dc_carry;
    logic        hc_inc = 1'b0;
    logic [4:0]  hc_cnt;
    logic        hc_carry;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    watch_top dut (
        .clk(clk), .reset(reset), .i_run_en(run_en), .i_freq(freq),
        .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_day(o_day)
    );

    // day-width and hour-width stages on their own, to reach the wrap points cheaply
    watch_counter #(.W(9), .MAX(511)) u_dc (
        .clk(clk), .reset(reset), .i_inc(dc_inc), .o_cnt(dc_cnt), .o_carry(dc_carry)
    );
    watch_counter #(.W(5), .MAX(23)) u_hc (
        .clk(clk), .reset(reset), .i_inc(hc_inc), .o_cnt(hc_cnt), .o_carry(hc_carry)
    );

    function automatic void check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: total elapsed seconds plus position within the current second.
    longint m_secs  = 0;
    longint m_ph    = 0;
    bit     m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_secs  = 0;
            m_ph    = 0;
            m_valid = 1'b1;
        end else if (run_en) begin
            if (freq <= 1 || m_ph + 1 >= freq) begin
                m_ph = 0;
                m_secs++;
            end else begin
                m_ph++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_sec",  o_sec,  m_secs % 60);
            check("m_min",  o_min,  (m_secs / 60) % 60);
            check("m_hour", o_hour, (m_secs / 3600) % 24);
            check("m_day",  o_day,  (m_secs / 86400) % 512);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_time(string name, int h, int m, int s);
        check({name, "_hour"}, o_hour, h);
        check({name, "_min"},  o_min,  m);
        check({name, "_sec"},  o_sec,  s);
        check({name, "_day"},  o_day,  0);
    endtask

    initial begin
        cyc(1);
        reset = 1'b0;
        cyc(50);
        expect_time("idle", 0, 0, 0);

        run_en = 1'b1;
        cyc(9);
        expect_time("pre_tick", 0, 0, 0);
        cyc(1);
        expect_time("first_tick", 0, 0, 1);
        cyc(590);
        expect_time("one_min", 0, 1, 0);

        // freeze mid-second: the next tick slips by the frozen cycles
        cyc(3);
        run_en = 1'b0;
        cyc(7);
        expect_time("frozen", 0, 1, 0);
        run_en = 1'b1;
        cyc(6);
        expect_time("resume_pre", 0, 1, 0);
        cyc(1);
        expect_time("resume_tick", 0, 1, 1);

        // lowering i_freq below the current phase fires on the next edge
        cyc(4);
        freq = 30'd3;
        cyc(1);
        expect_time("freq_drop", 0, 1, 2);
        cyc(3);
        expect_time("freq3", 0, 1, 3);
        freq = 30'd1;
        cyc(5);
        expect_time("freq1", 0, 1, 8);
        freq = 30'd0;
        cyc(5);
        expect_time("freq0", 0, 1, 13);

        reset = 1'b1;
        cyc(1);
        expect_time("reset1", 0, 0, 0);
        reset = 1'b0;
        freq  = 30'd1;
        cyc(3599);
        expect_time("h0_59_59", 0, 59, 59);
        cyc(1);
        expect_time("h1", 1, 0, 0);
        cyc(125);
        expect_time("h1_02_05", 1, 2, 5);

        // reset while running and mid-second
        freq = 30'd10;
        cyc(5);
        reset = 1'b1;
        cyc(1);
        expect_time("reset_mid", 0, 0, 0);
        reset = 1'b0;
        cyc(23);
        expect_time("after_reset", 0, 0, 2);
        run_en = 1'b0;

        dc_inc = 1'b1;
        hc_inc = 1'b1;
        cyc(23);
        check("hc_at_max", hc_cnt, 23);
        check("hc_carry",  hc_carry, 1);
        cyc(1);
        check("hc_wrap",   hc_cnt, 0);
        check("hc_nocarry", hc_carry, 0);
        hc_inc = 1'b0;
        cyc(487);
        check("dc_at_max", dc_cnt, 511);
        check("dc_carry",  dc_carry, 1);
        cyc(1);
        check("dc_wrap",   dc_cnt, 0);
        dc_inc = 1'b0;
        cyc(2);
        check("dc_hold",   dc_cnt, 0);
        check("dc_idle_carry", dc_carry, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
